rr_arb_2x1: RTL

RR_ARB_2X1 -- requirements
Module: rr_arb_2x1

---
 rtl/rr_arb_2x1.sv | 109 ++++++++++
 1 files changed

// File: rtl/rr_arb_2x1.sv
// rr_arb_2x1: two-source round-robin arbiter feeding a single registered
// output slot. Source readies are combinational; the output word, its source
// index and the handshake counter are registered.
module rr_arb_2x1 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         sel,
  output logic [15:0]  xfer_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_data;
  logic [W-1:0]     w_data_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_gnt0;
  logic             w_gnt1;

  // State, payload, source index, tie-break history and handshake counter.
  // last resets to 1 so that source 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Load/grant decision and next-state; a tie goes to the source not granted last.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;

    w_load = ((r_state == ST_EMPTY) || out_ready) && !rst;
    w_gnt0 = w_load && in0_valid && (!in1_valid || r_last);
    w_gnt1 = w_load && in1_valid && (!in0_valid || !r_last);

    if ((r_state == ST_FULL) && out_ready) begin
      w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
    end

    unique case (r_state)
      ST_EMPTY: begin
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready && !(w_gnt0 || w_gnt1)) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    if (w_gnt0) begin
      w_data_nxt = in0_data;
      w_sel_nxt  = 1'b0;
      w_last_nxt = 1'b0;
    end else if (w_gnt1) begin
      w_data_nxt = in1_data;
      w_sel_nxt  = 1'b1;
      w_last_nxt = 1'b1;
    end
  end

  assign in0_ready = w_gnt0;
  assign in1_ready = w_gnt1;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign sel       = r_sel;
  assign xfer_cnt  = r_cnt;

endmodule
